// File: rtl/avalon_msg_enforcer_if.sv
// Avalon-ST bus bundle: data, valid, rdy, sop, eop, empty.
// The empty field is wide enough to carry out-of-range values such as
// DATA_WIDTH_IN_BYTES itself, so that a misbehaving source can be detected.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES + 1);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, output valid, output sop, output eop, output empty, input rdy);
  modport slave  (input data, input valid, input sop, input eop, input empty, output rdy);
endinterface

// File: rtl/avalon_msg_enforcer.sv
// Avalon-ST message enforcer. Cleans an untrusted stream: drops beats outside
// a message, strips stray SOPs, masks bytes past the EOP empty count, truncates
// messages longer than MAX_MSG_BEATS (discarding the rest), and keeps
// saturating event counters. The output is a single register stage.
module avalon_msg_enforcer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_BEATS       = 64,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           untrusted_msg,
  avalon_st_if.master          enforced_msg,
  input  logic                 clear_counters,
  output logic                 missing_sop_indi,
  output logic                 unexpected_sop_indi,
  output logic                 oversize_indi,
  output logic                 bad_empty_indi,
  output logic [CNT_WIDTH-1:0] missing_sop_cnt,
  output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
  output logic [CNT_WIDTH-1:0] oversize_cnt,
  output logic [CNT_WIDTH-1:0] bad_empty_cnt
);

  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = $clog2(DATA_WIDTH_IN_BYTES + 1);
  localparam int BW = $clog2(MAX_MSG_BEATS + 1);

  localparam logic [EW-1:0]        BYTES_E   = EW'(DATA_WIDTH_IN_BYTES);
  localparam logic [EW-1:0]        MAX_EMPTY = EW'(DATA_WIDTH_IN_BYTES - 1);
  localparam logic [BW-1:0]        LAST_CNT  = BW'(MAX_MSG_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IN_MSG  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Saturating increment: holds at all-ones once reached.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 en);
    logic [CNT_WIDTH-1:0] res;
    if (en && (cnt != CNT_MAX)) res = cnt + CNT_WIDTH'(1);
    else                        res = cnt;
    return res;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW-1:0]        r_beat_cnt;
  logic [BW-1:0]        w_beat_cnt_nxt;

  logic                 r_out_valid;
  logic                 r_out_sop;
  logic                 r_out_eop;
  logic [EW-1:0]        r_out_empty;
  logic [DW-1:0]        r_out_data;

  logic                 r_missing_indi;
  logic                 r_unexp_indi;
  logic                 r_over_indi;
  logic                 r_bad_indi;
  logic [CNT_WIDTH-1:0] r_missing_cnt;
  logic [CNT_WIDTH-1:0] r_unexp_cnt;
  logic [CNT_WIDTH-1:0] r_over_cnt;
  logic [CNT_WIDTH-1:0] r_bad_cnt;

  logic                 w_accept;
  logic                 w_bad_empty_in;
  logic [EW-1:0]        w_eop_empty;
  logic [DW-1:0]        w_masked;
  logic                 w_fwd;
  logic                 w_sop;
  logic                 w_eop;
  logic [EW-1:0]        w_empty;
  logic [DW-1:0]        w_data;
  logic                 w_missing;
  logic                 w_unexp;
  logic                 w_over;
  logic                 w_bad;

  // Single output register: accept whenever it is empty or being drained.
  assign untrusted_msg.rdy = ~r_out_valid | enforced_msg.rdy;
  assign w_accept          = untrusted_msg.valid & untrusted_msg.rdy;

  assign enforced_msg.valid = r_out_valid;
  assign enforced_msg.sop   = r_out_sop;
  assign enforced_msg.eop   = r_out_eop;
  assign enforced_msg.empty = r_out_empty;
  assign enforced_msg.data  = r_out_data;

  assign missing_sop_indi    = r_missing_indi;
  assign unexpected_sop_indi = r_unexp_indi;
  assign oversize_indi       = r_over_indi;
  assign bad_empty_indi      = r_bad_indi;
  assign missing_sop_cnt     = r_missing_cnt;
  assign unexpected_sop_cnt  = r_unexp_cnt;
  assign oversize_cnt        = r_over_cnt;
  assign bad_empty_cnt       = r_bad_cnt;

  // Clamp an out-of-range empty and zero the trailing invalid bytes of a real EOP beat.
  always_comb begin
    w_bad_empty_in = (untrusted_msg.empty >= BYTES_E);
    if (w_bad_empty_in) w_eop_empty = MAX_EMPTY;
    else                w_eop_empty = untrusted_msg.empty;
    w_masked = untrusted_msg.data;
    for (int k = 0; k < DATA_WIDTH_IN_BYTES; k++) begin
      if (k >= (DATA_WIDTH_IN_BYTES - int'(w_eop_empty)))
        w_masked[8*(DATA_WIDTH_IN_BYTES-k)-1 -: 8] = 8'h00;
      else
        w_masked[8*(DATA_WIDTH_IN_BYTES-k)-1 -: 8] = untrusted_msg.data[8*(DATA_WIDTH_IN_BYTES-k)-1 -: 8];
    end
  end

  // Message-framing decode for the beat currently offered on the input.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_fwd          = 1'b0;
    w_sop          = 1'b0;
    w_eop          = 1'b0;
    w_empty        = '0;
    w_data         = untrusted_msg.data;
    w_missing      = 1'b0;
    w_unexp        = 1'b0;
    w_over         = 1'b0;
    w_bad          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (untrusted_msg.sop) begin
          w_fwd = 1'b1;
          w_sop = 1'b1;
          if (untrusted_msg.eop) begin
            w_eop   = 1'b1;
            w_empty = w_eop_empty;
            w_data  = w_masked;
            w_bad   = w_bad_empty_in;
          end else if (MAX_MSG_BEATS == 1) begin
            // A one-beat limit truncates right on the SOP beat.
            w_eop       = 1'b1;
            w_over      = 1'b1;
            w_state_nxt = S_DISCARD;
          end else begin
            w_beat_cnt_nxt = BW'(1);
            w_state_nxt    = S_IN_MSG;
          end
        end else begin
          w_missing = 1'b1;
        end
      end
      S_IN_MSG: begin
        w_fwd   = 1'b1;
        w_unexp = untrusted_msg.sop;
        if (untrusted_msg.eop) begin
          w_eop          = 1'b1;
          w_empty        = w_eop_empty;
          w_data         = w_masked;
          w_bad          = w_bad_empty_in;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else if (r_beat_cnt == LAST_CNT) begin
          // Limit reached: close the message here, drop the remainder.
          w_eop          = 1'b1;
          w_over         = 1'b1;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_DISCARD;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt + BW'(1);
        end
      end
      S_DISCARD: begin
        w_unexp = untrusted_msg.sop;
        if (untrusted_msg.eop) w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_DISCARD;
      end
      default: begin
        w_beat_cnt_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // FSM state, output register stage, event pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_beat_cnt     <= '0;
      r_out_valid    <= 1'b0;
      r_out_sop      <= 1'b0;
      r_out_eop      <= 1'b0;
      r_out_empty    <= '0;
      r_out_data     <= '0;
      r_missing_indi <= 1'b0;
      r_unexp_indi   <= 1'b0;
      r_over_indi    <= 1'b0;
      r_bad_indi     <= 1'b0;
      r_missing_cnt  <= '0;
      r_unexp_cnt    <= '0;
      r_over_cnt     <= '0;
      r_bad_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_state    <= w_state_nxt;
        r_beat_cnt <= w_beat_cnt_nxt;
      end

      if (w_accept && w_fwd) begin
        r_out_valid <= 1'b1;
        r_out_sop   <= w_sop;
        r_out_eop   <= w_eop;
        r_out_empty <= w_empty;
        r_out_data  <= w_data;
      end else if (enforced_msg.rdy) begin
        r_out_valid <= 1'b0;
      end

      r_missing_indi <= w_accept & w_missing;
      r_unexp_indi   <= w_accept & w_unexp;
      r_over_indi    <= w_accept & w_over;
      r_bad_indi     <= w_accept & w_bad;

      if (clear_counters) begin
        r_missing_cnt <= '0;
        r_unexp_cnt   <= '0;
        r_over_cnt    <= '0;
        r_bad_cnt     <= '0;
      end else begin
        r_missing_cnt <= sat_inc(r_missing_cnt, w_accept & w_missing);
        r_unexp_cnt   <= sat_inc(r_unexp_cnt,   w_accept & w_unexp);
        r_over_cnt    <= sat_inc(r_over_cnt,    w_accept & w_over);
        r_bad_cnt     <= sat_inc(r_bad_cnt,     w_accept & w_bad);
      end
    end
  end

endmodule

// File: tb/tb_avalon_msg_enforcer.sv
// Directed bench for avalon_msg_enforcer (16 bytes/beat, 4-beat limit,
// 4-bit counters so that saturation is reachable quickly).
module tb_avalon_msg_enforcer;

  localparam int NB   = 16;
  localparam int MAXB = 4;
  localparam int CW   = 4;
  localparam int DW   = 8 * NB;
  localparam int EW   = 5;
  localparam int CKW  = 160;

  localparam logic [DW-1:0] D1    = 128'h0123456789ABCDEF0011223344556677;
  localparam logic [DW-1:0] D2    = 128'h8899AABBCCDDEEFF7766554433221100;
  localparam logic [DW-1:0] D3    = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [DW-1:0] D3M5  = {88'hFFEEDDCCBBAA9988776655, 40'h0};
  localparam logic [DW-1:0] D3B0  = {8'hFF, 120'h0};
  localparam logic [DW-1:0] D4    = 128'hDEADBEEFCAFEF00D1234567890ABCDEF;
  localparam logic [DW-1:0] D5    = 128'h55AA55AA55AA55AA0F0F0F0F0F0F0F0F;

  logic clk = 1'b0;
  logic rst;
  logic clear_counters;
  logic missing_sop_indi, unexpected_sop_indi, oversize_indi, bad_empty_indi;
  logic [CW-1:0] missing_sop_cnt, unexpected_sop_cnt, oversize_cnt, bad_empty_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) u_in ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) u_out ();

  avalon_msg_enforcer #(
    .DATA_WIDTH_IN_BYTES(NB),
    .MAX_MSG_BEATS(MAXB),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .untrusted_msg(u_in),
    .enforced_msg(u_out),
    .clear_counters(clear_counters),
    .missing_sop_indi(missing_sop_indi),
    .unexpected_sop_indi(unexpected_sop_indi),
    .oversize_indi(oversize_indi),
    .bad_empty_indi(bad_empty_indi),
    .missing_sop_cnt(missing_sop_cnt),
    .unexpected_sop_cnt(unexpected_sop_cnt),
    .oversize_cnt(oversize_cnt),
    .bad_empty_cnt(bad_empty_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [EW-1:0] empty,
                       input logic [DW-1:0] data);
    u_in.valid = 1'b1;
    u_in.sop   = sop;
    u_in.eop   = eop;
    u_in.empty = empty;
    u_in.data  = data;
    tick();
  endtask

  task automatic idle();
    u_in.valid = 1'b0;
    u_in.sop   = 1'b0;
    u_in.eop   = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic s, input logic e,
                         input logic [EW-1:0] emp, input logic [DW-1:0] d);
    check({tag, "_valid"}, u_out.valid, v);
    if (v) begin
      check({tag, "_sop"},   u_out.sop, s);
      check({tag, "_eop"},   u_out.eop, e);
      check({tag, "_empty"}, u_out.empty, emp);
      check({tag, "_data"},  u_out.data, d);
    end
  endtask

  task automatic chk_indi(input string tag, input logic [3:0] exp);
    check({tag, "_indi"},
          {missing_sop_indi, unexpected_sop_indi, oversize_indi, bad_empty_indi}, exp);
  endtask

  logic [DW-1:0]  in_data [10];
  logic           in_sop  [10];
  logic           in_eop  [10];
  logic [DW+1:0]  exp_q   [10];

  initial begin
    logic [7:0]    b;
    logic [DW-1:0] d;
    logic          ordy, acc, prev_stall, exp_rdy;
    logic [DW+1:0] held;
    int            idx, rcv;

    rst = 1'b1;
    clear_counters = 1'b0;
    u_in.valid = 1'b0; u_in.sop = 1'b0; u_in.eop = 1'b0; u_in.empty = '0; u_in.data = '0;
    u_out.rdy = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_valid", u_out.valid, 1'b0);
    check("rst_fields", {u_out.sop, u_out.eop, u_out.empty, u_out.data}, '0);
    chk_indi("rst", 4'b0000);
    check("rst_cnts", {missing_sop_cnt, unexpected_sop_cnt, oversize_cnt, bad_empty_cnt}, 16'h0000);
    rst = 1'b0;
    idle();

    // Normal 3-beat message, empty=5 on the EOP beat
    drive(1'b1, 1'b0, 5'd0, D1); chk_out("t1b1", 1'b1, 1'b1, 1'b0, 5'd0, D1); chk_indi("t1b1", 4'b0000);
    drive(1'b0, 1'b0, 5'd0, D2); chk_out("t1b2", 1'b1, 1'b0, 1'b0, 5'd0, D2);
    drive(1'b0, 1'b1, 5'd5, D3); chk_out("t1b3", 1'b1, 1'b0, 1'b1, 5'd5, D3M5); chk_indi("t1b3", 4'b0000);
    idle(); check("t1_drain", u_out.valid, 1'b0);
    check("t1_cnts", {missing_sop_cnt, unexpected_sop_cnt, oversize_cnt, bad_empty_cnt}, 16'h0000);

    // Beats without SOP while idle are dropped
    drive(1'b0, 1'b0, 5'd0, D1); check("t2_drop1", u_out.valid, 1'b0); chk_indi("t2_drop1", 4'b1000);
    drive(1'b0, 1'b1, 5'd0, D2); check("t2_drop2", u_out.valid, 1'b0); chk_indi("t2_drop2", 4'b1000);
    check("t2_miss_cnt", missing_sop_cnt, 4'd2);
    drive(1'b1, 1'b0, 5'd0, D4); chk_out("t2b1", 1'b1, 1'b1, 1'b0, 5'd0, D4); chk_indi("t2b1", 4'b0000);
    drive(1'b0, 1'b1, 5'd0, D5); chk_out("t2b2", 1'b1, 1'b0, 1'b1, 5'd0, D5);
    idle();

    // 7-beat message truncated at 4 beats
    for (int i = 0; i < 7; i++) begin
      b = 8'h10 + 8'(i);
      d = {NB{b}};
      drive(i == 0, i == 6, (i == 6) ? 5'd3 : 5'd0, d);
      if (i < 3) begin
        chk_out($sformatf("t3b%0d", i), 1'b1, i == 0, 1'b0, 5'd0, d);
        chk_indi($sformatf("t3b%0d", i), 4'b0000);
      end else if (i == 3) begin
        chk_out("t3b3", 1'b1, 1'b0, 1'b1, 5'd0, d);
        chk_indi("t3b3", 4'b0010);
      end else begin
        check($sformatf("t3drop%0d", i), u_out.valid, 1'b0);
        chk_indi($sformatf("t3drop%0d", i), 4'b0000);
      end
    end
    check("t3_over_cnt", oversize_cnt, 4'd1);
    drive(1'b1, 1'b1, 5'd0, D1); chk_out("t3_next", 1'b1, 1'b1, 1'b1, 5'd0, D1); chk_indi("t3_next", 4'b0000);
    idle();

    // Stray SOP inside a message
    drive(1'b1, 1'b0, 5'd0, D1); chk_out("t4b1", 1'b1, 1'b1, 1'b0, 5'd0, D1);
    drive(1'b1, 1'b0, 5'd0, D2); chk_out("t4b2", 1'b1, 1'b0, 1'b0, 5'd0, D2); chk_indi("t4b2", 4'b0100);
    drive(1'b0, 1'b1, 5'd0, D3); chk_out("t4b3", 1'b1, 1'b0, 1'b1, 5'd0, D3); chk_indi("t4b3", 4'b0000);
    check("t4_unexp_cnt", unexpected_sop_cnt, 4'd1);
    idle();

    // Random backpressure over 10 beats (messages of 4, 4 and 2 beats)
    for (int i = 0; i < 10; i++) begin
      b = 8'hA0 + 8'(i);
      in_data[i] = {NB{b}};
      in_sop[i]  = (i == 0) || (i == 4) || (i == 8);
      in_eop[i]  = (i == 3) || (i == 7) || (i == 9);
      exp_q[i]   = {in_sop[i], in_eop[i], in_data[i]};
    end
    idx = 0; rcv = 0; prev_stall = 1'b0; held = '0;
    u_in.valid = 1'b1; u_in.sop = in_sop[0]; u_in.eop = in_eop[0]; u_in.empty = 5'd0; u_in.data = in_data[0];
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      if (prev_stall) check("t5_hold", {u_out.sop, u_out.eop, u_out.data}, held);
      ordy = 1'($urandom_range(0, 1));
      u_out.rdy = ordy;
      #1;
      exp_rdy = ~u_out.valid | ordy;
      check("t5_rdy", u_in.rdy, exp_rdy);
      if (u_out.valid && ordy) begin
        check($sformatf("t5_beat%0d", rcv), {u_out.sop, u_out.eop, u_out.data}, exp_q[rcv]);
        rcv++;
      end
      acc = u_in.valid & u_in.rdy;
      prev_stall = u_out.valid & ~ordy;
      held = {u_out.sop, u_out.eop, u_out.data};
      tick();
      if (acc) begin
        idx++;
        if (idx < 10) begin
          u_in.sop = in_sop[idx]; u_in.eop = in_eop[idx]; u_in.data = in_data[idx];
        end else begin
          u_in.valid = 1'b0;
        end
      end
    end
    check("t5_count", rcv, 10);
    u_out.rdy = 1'b1;
    idle();

    // Out-of-range empty, counter saturation, then clear
    check("t6_bad_cnt0", bad_empty_cnt, 4'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 5'd16, D3);
      if (i == 0) begin
        chk_out("t6b0", 1'b1, 1'b1, 1'b1, 5'd15, D3B0);
        chk_indi("t6b0", 4'b0001);
      end
    end
    chk_indi("t6_last", 4'b0001);
    check("t6_bad_sat", bad_empty_cnt, 4'd15);
    u_in.valid = 1'b0;
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    check("t6_clear", {missing_sop_cnt, unexpected_sop_cnt, oversize_cnt, bad_empty_cnt}, 16'h0000);

    // Reset in the middle of a message
    drive(1'b1, 1'b0, 5'd0, D1); chk_out("t7b1", 1'b1, 1'b1, 1'b0, 5'd0, D1);
    u_in.valid = 1'b0;
    u_out.rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_out.rdy = 1'b1;
    check("t7_rst_valid", u_out.valid, 1'b0);
    drive(1'b0, 1'b0, 5'd0, D2); check("t7_drop", u_out.valid, 1'b0); chk_indi("t7_drop", 4'b1000);
    check("t7_miss_cnt", missing_sop_cnt, 4'd1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avalon_msg_enforcer.md
Name: avalon_msg_enforcer

Overview:
- Successor of the streaming enforcer. Sits between an untrusted Avalon-ST source and downstream consumers.
- Drops beats outside a message and strips stray SOPs. Masks invalid bytes on the EOP beat.
- New in this generation: enforces a maximum message length by truncating and discarding, adds a registered output stage, and keeps saturating error counters.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, bytes per beat; data width = 8*DATA_WIDTH_IN_BYTES.
- MAX_MSG_BEATS, 64, maximum forwarded beats per message (>=1).
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  input  1  clock. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset.
- untrusted_msg  avalon_st_if.slave  -  input stream (data, valid, rdy, sop, eop, empty).
- enforced_msg  avalon_st_if.master  -  cleaned output stream.
- clear_counters  input  1  synchronous clear of all error counters.
- missing_sop_indi  output  1  pulse: a beat was dropped outside a message.
- unexpected_sop_indi  output  1  pulse: SOP seen inside a message, or while discarding.
- oversize_indi  output  1  pulse: message truncated at MAX_MSG_BEATS.
- bad_empty_indi  output  1  pulse: EOP beat with empty >= DATA_WIDTH_IN_BYTES.
- missing_sop_cnt, unexpected_sop_cnt, oversize_cnt, bad_empty_cnt  output  CNT_WIDTH each  saturating event counters.

Behaviour:
- Accept: accept = untrusted_msg.valid & untrusted_msg.rdy.
- Ready: untrusted_msg.rdy = ~out_valid | enforced_msg.rdy. This is a single output register, with no combinational path from input data to output.
- Output register: loads on accept of a forwarded beat. out_valid clears on enforced_msg.rdy when no new beat is loaded. Latency is 1 cycle. Output holds stable while valid & ~rdy.
- Reset (rst=1 at posedge): state=IDLE, beat_cnt=0, out_valid=0, enforced_msg.sop/eop/empty/data=0, all indi=0, all counters=0.
- State on an accepted beat:
  - IDLE, sop=1, eop=1: forward with sop=1, eop=1; stay IDLE.
  - IDLE, sop=1, eop=0: forward with sop=1; beat_cnt=1; go to IN_MSG. If MAX_MSG_BEATS==1: force eop=1, empty=0, pulse oversize_indi, go to DISCARD.
  - IDLE, sop=0: drop the beat; pulse missing_sop_indi.
  - IN_MSG: forward with sop forced to 0. If input sop=1, pulse unexpected_sop_indi (the beat is still forwarded).
    - eop=1: forward eop; go to IDLE.
    - eop=0 and beat_cnt+1==MAX_MSG_BEATS: force eop=1, empty=0; pulse oversize_indi; go to DISCARD.
    - otherwise: beat_cnt++.
  - DISCARD: drop all beats. If sop=1, pulse unexpected_sop_indi. If eop=1, go to IDLE.
- Empty and data masking:
  - Non-EOP forwarded beats: empty=0, data passed unmodified.
  - EOP forwarded beat: empty=e. Byte k occupies data[8*(DATA_WIDTH_IN_BYTES-k)-1 -: 8]; byte 0 is the first symbol, in the MSBs.
  - Bytes k >= DATA_WIDTH_IN_BYTES-e are forced to 0.
  - e >= DATA_WIDTH_IN_BYTES: clamp to DATA_WIDTH_IN_BYTES-1, pulse bad_empty_indi.
  - Forced-EOP (truncation) beats: empty=0, no masking.
- Indications: each *_indi is registered, high exactly 1 cycle after the accepting edge. Several may be high together, e.g. unexpected SOP plus oversize on the same beat.
- Counters:
  - Increment by 1 on the same edge that sets the matching indi.
  - Saturate at all-ones.
  - clear_counters has priority over increment; rst has priority over clear_counters.
- Idle input: valid=0 causes no state change and no pulses.
- Reset mid-message: state returns to IDLE. Any pending output beat is discarded (out_valid=0). The next non-SOP input beats count as missing_sop.

Test Plan:
- Normal 3-beat message, DATA_WIDTH_IN_BYTES=16, eop empty=5, rdy=1 -> 3 output beats 1 cycle later; beat3 low 40 bits =0, empty=5; no indi; counters 0.
- 2 beats with sop=0 in IDLE, then a valid 2-beat message -> first 2 beats dropped; missing_sop_cnt=2; message forwarded intact.
- MAX_MSG_BEATS=4, 7-beat message -> 4 beats out, beat4 eop=1, empty=0; beats 5-7 dropped; oversize_cnt=1; next message forwarded normally.
- SOP on beat2 of a 3-beat message -> 3 beats out, only beat1 sop=1; unexpected_sop_indi pulses once.
- enforced_msg.rdy toggled 1/0 randomly over a 10-beat message -> no beat lost or duplicated; output stable while stalled; untrusted_msg.rdy=0 only when out_valid & ~enforced_msg.rdy.
- eop beat with empty=16; counter preloaded to saturation with CNT_WIDTH=4 -> empty out=15, only byte 0 kept; bad_empty_cnt stays at 15; clear_counters -> 0.
